// File: rtl/hall_pkg.sv
// Shared hall-sensor definitions: six-step code table, fault codes, fault_mode encodings.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a. Used by hall_emulator and the six-step decoder.
package hall_pkg;

    typedef logic [2:0] hall_code_t;   // {hall1/A, hall2/B, hall3/C}
    typedef logic [2:0] step_idx_t;    // legal range 0..5

    localparam int unsigned NUM_STEPS = 6;

    typedef enum logic [1:0] {
        FM_NORMAL     = 2'b00,
        FM_FORCE_LO   = 2'b01,
        FM_FORCE_HI   = 2'b10,
        FM_NORMAL_ALT = 2'b11
    } fault_mode_e;

    localparam hall_code_t HALL_FAULT_LO = 3'b000;
    localparam hall_code_t HALL_FAULT_HI = 3'b111;

    // Forward order; high phase per pair of steps is A,A,B,B,C,C.
    localparam hall_code_t HALL_CODE0 = 3'b101;
    localparam hall_code_t HALL_CODE1 = 3'b100;
    localparam hall_code_t HALL_CODE2 = 3'b110;
    localparam hall_code_t HALL_CODE3 = 3'b010;
    localparam hall_code_t HALL_CODE4 = 3'b011;
    localparam hall_code_t HALL_CODE5 = 3'b001;

    // Out-of-range indices map to step 0's code so hall never shows 000/111.
    function automatic hall_code_t hall_code(input step_idx_t idx);
        case (idx)
            3'd1:    return HALL_CODE1;
            3'd2:    return HALL_CODE2;
            3'd3:    return HALL_CODE3;
            3'd4:    return HALL_CODE4;
            3'd5:    return HALL_CODE5;
            default: return HALL_CODE0;
        endcase
    endfunction

    function automatic logic fault_is_forced(input logic [1:0] fm);
        return (fault_mode_e'(fm) == FM_FORCE_LO) || (fault_mode_e'(fm) == FM_FORCE_HI);
    endfunction

endpackage

// File: rtl/hall_step_timer.sv
// Prescaler: emits a combinational step pulse when cnt reaches step_period-1.
// Latency: step asserts in the cycle cnt >= step_period-1; cnt returns to 0 on that edge.
// Backpressure: none. Ports: clk, rst_n, en, run (fault-free), step_period -> step.
module hall_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                run,
    input  logic [PERIOD_W-1:0] step_period,
    output logic                step
);

    logic [PERIOD_W-1:0] cnt;
    logic                active;

    assign active = en && run && (step_period != '0);

    // >= rather than == so that shrinking step_period below cnt steps at once
    // instead of letting cnt wrap all the way round.
    assign step = active && (cnt >= step_period - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + PERIOD_W'(1);
        end
        // period 0 or forced fault: cnt frozen
    end

endmodule

// File: rtl/hall_emulator.sv
// Hall-sensor emulator: walks the six-step hall sequence at step_period cycles per step.
// Latency: hall/step_strobe/step_count update on the step edge itself (all registered).
// Backpressure: none. Ports: clk, rst_n, en, dir, step_period, fault_mode -> hall, step_strobe, step_count.
module hall_emulator
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic [1:0]          fault_mode,
    output logic [2:0]          hall,
    output logic                step_strobe,
    output logic [COUNT_W-1:0]  step_count
);

    logic      step;
    logic      forced;
    step_idx_t idx;
    step_idx_t idx_ok;
    step_idx_t idx_nxt;

    assign forced = fault_is_forced(fault_mode);

    hall_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .run         (!forced),
        .step_period (step_period),
        .step        (step)
    );

    // Illegal index (6/7) is treated as 0 and written back on the next edge.
    assign idx_ok = (idx < step_idx_t'(NUM_STEPS)) ? idx : '0;

    always_comb begin
        idx_nxt = idx_ok;
        if (dir) begin
            idx_nxt = (idx_ok == 3'd0) ? 3'd5 : idx_ok - 3'd1;
        end else begin
            idx_nxt = (idx_ok == 3'd5) ? 3'd0 : idx_ok + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            hall        <= HALL_CODE0;
            step_count  <= '0;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= step;

            if (step) begin
                idx        <= idx_nxt;
                // dir=1 adds all-ones (-1), dir=0 adds +1
                step_count <= step_count + {{(COUNT_W-1){dir}}, 1'b1};
            end else begin
                idx        <= idx_ok;
            end

            if (fault_mode_e'(fault_mode) == FM_FORCE_LO) begin
                hall <= HALL_FAULT_LO;
            end else if (fault_mode_e'(fault_mode) == FM_FORCE_HI) begin
                hall <= HALL_FAULT_HI;
            end else if (step) begin
                hall <= hall_code(idx_nxt);
            end else begin
                hall <= hall_code(idx_ok);
            end
        end
    end

endmodule

// File: tb/tb_hall_emulator.sv
module tb_hall_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] step_period = 16'd0;
    logic [1:0]  fault_mode = 2'b00;
    logic [2:0]  hall;
    logic        step_strobe;
    logic [15:0] step_count;

    always #5 clk = ~clk;

    hall_emulator #(.PERIOD_W(16), .COUNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dir         (dir),
        .step_period (step_period),
        .fault_mode  (fault_mode),
        .hall        (hall),
        .step_strobe (step_strobe),
        .step_count  (step_count)
    );

    typedef struct packed {
        logic [2:0]  hall;
        logic        strobe;
        logic [15:0] count;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // Reference model: signed net position plus a cycle counter toward the next step.
    longint      m_pos = 0;
    int unsigned m_cnt = 0;
    logic [2:0]  codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    function automatic logic [2:0] code_at(input longint p);
        longint r;
        r = p % 6;
        if (r < 0) r = r + 6;
        return codes[int'(r)];
    endfunction

    // Apply one cycle of inputs and queue what the DUT must show after the edge.
    task automatic drive(input logic r, input logic e, input logic d,
                         input logic [15:0] per, input logic [1:0] fm);
        exp_t x;
        logic forced;
        @(negedge clk);
        rst_n = r; en = e; dir = d; step_period = per; fault_mode = fm;
        forced = (fm == 2'b01) || (fm == 2'b10);
        x.strobe = 1'b0;
        if (!r) begin
            m_pos = 0;
            m_cnt = 0;
        end else if (!e) begin
            m_cnt = 0;
        end else if (!forced && per != 16'd0) begin
            if (m_cnt + 1 >= per) begin
                if (d) m_pos = m_pos - 1; else m_pos = m_pos + 1;
                m_cnt = 0;
                x.strobe = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (!r)              x.hall = 3'b101;
        else if (fm == 2'b01) x.hall = 3'b000;
        else if (fm == 2'b10) x.hall = 3'b111;
        else                  x.hall = code_at(m_pos);
        x.count = m_pos[15:0];
        q.push_back(x);
        n_push++;
    endtask

    task automatic run(input int n, input logic e, input logic d,
                       input logic [15:0] per, input logic [1:0] fm);
        for (int i = 0; i < n; i++) drive(1'b1, e, d, per, fm);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'd3, 2'b00);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every edge the DUT presents a fresh output triple; compare to queue head.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            n_pop++;
            n_cmp++;
            if ({hall, step_strobe, step_count} !== x) begin
                n_bad++;
                $display("FAIL stream #%0d: hall %b strobe %b count %h, expected hall %b strobe %b count %h",
                         n_pop, hall, step_strobe, step_count, x.hall, x.strobe, x.count);
            end
        end
    end

    initial begin
        logic        r, e, d;
        logic [15:0] per;
        logic [1:0]  fm;

        // reset state
        do_reset();
        do_reset();
        settle();
        chk("reset_hall", 16'(hall), 16'h5);
        chk("reset_count", step_count, 16'h0);
        chk("reset_strobe", 16'(step_strobe), 16'h0);

        // forward, period 4
        run(4, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("fwd4_first_hall", 16'(hall), 16'h4);
        chk("fwd4_first_strobe", 16'(step_strobe), 16'h1);
        run(20, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("fwd4_count", step_count, 16'd6);
        chk("fwd4_wrap_hall", 16'(hall), 16'h5);

        // reverse, period 3
        do_reset();
        run(2, 1'b1, 1'b1, 16'd3, 2'b00);
        settle();
        chk("rev3_hold_hall", 16'(hall), 16'h5);
        run(1, 1'b1, 1'b1, 16'd3, 2'b00);
        settle();
        chk("rev3_hall", 16'(hall), 16'h1);
        chk("rev3_count", step_count, 16'hFFFF);

        // live period decrease: cnt=7 at period 10, then period 5
        do_reset();
        run(7, 1'b1, 1'b0, 16'd10, 2'b00);
        settle();
        chk("shrink_before", 16'(hall), 16'h5);
        run(1, 1'b1, 1'b0, 16'd5, 2'b00);
        settle();
        chk("shrink_step_hall", 16'(hall), 16'h4);
        chk("shrink_step_strobe", 16'(step_strobe), 16'h1);
        run(4, 1'b1, 1'b0, 16'd5, 2'b00);
        settle();
        chk("shrink_hold", 16'(hall), 16'h4);
        run(1, 1'b1, 1'b0, 16'd5, 2'b00);
        settle();
        chk("shrink_next", 16'(hall), 16'h6);

        // fault force-low at hall 110 with cnt frozen at 2
        do_reset();
        run(10, 1'b1, 1'b0, 16'd4, 2'b00);
        run(20, 1'b1, 1'b0, 16'd4, 2'b01);
        settle();
        chk("fault_hall", 16'(hall), 16'h0);
        chk("fault_count", step_count, 16'd2);
        run(1, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("fault_exit_hall", 16'(hall), 16'h6);
        run(1, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("fault_resume_hall", 16'(hall), 16'h2);
        chk("fault_resume_count", step_count, 16'd3);

        // period 1 every cycle, then reset overriding a forced fault
        do_reset();
        run(12, 1'b1, 1'b0, 16'd1, 2'b00);
        settle();
        chk("p1_strobe", 16'(step_strobe), 16'h1);
        chk("p1_count", step_count, 16'd12);
        chk("p1_hall", 16'(hall), 16'h5);
        drive(1'b0, 1'b1, 1'b0, 16'd1, 2'b01);
        settle();
        chk("rst_ovr_hall", 16'(hall), 16'h5);
        chk("rst_ovr_count", step_count, 16'h0);
        chk("rst_ovr_strobe", 16'(step_strobe), 16'h0);

        // count overflow 0x7FFF -> 0x8000, then en=0 clears cnt
        run(32767, 1'b1, 1'b0, 16'd1, 2'b00);
        settle();
        chk("ovf_pre", step_count, 16'h7FFF);
        run(1, 1'b1, 1'b0, 16'd1, 2'b00);
        settle();
        chk("ovf_count", step_count, 16'h8000);
        chk("ovf_hall", 16'(hall), 16'h6);
        run(2, 1'b1, 1'b0, 16'd4, 2'b00);
        run(5, 1'b0, 1'b0, 16'd4, 2'b00);
        settle();
        chk("en0_count", step_count, 16'h8000);
        chk("en0_strobe", 16'(step_strobe), 16'h0);
        run(3, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("en0_cleared_hold", 16'(hall), 16'h6);
        run(1, 1'b1, 1'b0, 16'd4, 2'b00);
        settle();
        chk("en0_cleared_step", 16'(hall), 16'h2);
        chk("en0_cleared_count", step_count, 16'h8001);

        // randomized traffic checked only by the monitor
        do_reset();
        per = 16'd3;
        d = 1'b0;
        fm = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) != 0);
            e = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 7) == 0) per = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) fm = 2'($urandom_range(0, 3));
            drive(r, e, d, per, fm);
        end

        settle();
        settle();
        chk("queue_drained", 16'(q.size()), 16'd0);
        chk("push_pop_match", 16'(n_pop), 16'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
